tube_disp_arbiter: RTL and testbench

- Shares the 8-digit seven-segment display datapath (digital_tube: 32-bit disp_data, en) among three requesters, e.g. counter, UART monitor and status.
- Uses round-robin arbitration with a minimum on-screen hold time and a blanking gap between owners to prevent ghosting.
- Sits directly upstream of digital_tube and drives its disp_data and en inputs.

---
 rtl/tube_disp_arbiter_if.sv | 24 ++
 rtl/tube_disp_arbiter.sv | 152 +++++++++++++++
 tb/tb_tube_disp_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/tube_disp_arbiter_if.sv
// Display-sharing bus between the three requesters and the tube arbiter.
// master: requester/driver side; slave: arbiter side.
interface tube_disp_arbiter_if;
  logic        disp_on;
  logic [2:0]  req;
  logic [31:0] src0_data;
  logic [31:0] src1_data;
  logic [31:0] src2_data;
  logic [2:0]  gnt;
  logic [1:0]  cur_src;
  logic [31:0] disp_data;
  logic        en;
  logic        switch_pulse;

  modport master (
    output disp_on, req, src0_data, src1_data, src2_data,
    input  gnt, cur_src, disp_data, en, switch_pulse
  );

  modport slave (
    input  disp_on, req, src0_data, src1_data, src2_data,
    output gnt, cur_src, disp_data, en, switch_pulse
  );
endinterface

// File: rtl/tube_disp_arbiter.sv
// Round-robin arbiter sharing the digital_tube datapath among three sources.
// Enforces a minimum on-screen hold time and a forced blank gap between owners.
module tube_disp_arbiter #(
  parameter int unsigned HOLD_CYC  = 50_000_000,
  parameter int unsigned BLANK_CYC = 500_000
) (
  input logic                clk,
  input logic                rst,
  tube_disp_arbiter_if.slave bus
);

  localparam logic [31:0] HoldLast  = 32'(HOLD_CYC - 1);
  localparam logic [31:0] BlankLast = 32'(BLANK_CYC - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  state_e      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] blank_cnt_q, blank_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        hold_done_q, hold_done_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [1:0]  cur_src_q, cur_src_d;
  logic [31:0] disp_data_q, disp_data_d;
  logic        en_q, en_d;
  logic        pulse_q, pulse_d;

  logic [31:0] owner_data;
  logic        owner_req;
  logic        hold_ok;
  logic [2:0]  pick_all;
  logic [2:0]  pick_other;

  // Returns {valid, index}; search order last+1, last+2, last (mod 3).
  function automatic logic [2:0] rr_pick(input logic [2:0] mask, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    // Walk from lowest to highest priority so the highest-priority hit wins.
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(last) + k) % 3);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Owner data select, request status and arbitration picks.
  always_comb begin
    owner_data = bus.src2_data;
    if (cur_src_q == 2'd0) owner_data = bus.src0_data;
    else if (cur_src_q == 2'd1) owner_data = bus.src1_data;
    owner_req  = |(bus.req & gnt_q);
    // Count is compared directly so the last hold cycle can already switch.
    hold_ok    = hold_done_q | (hold_cnt_q == HoldLast);
    pick_all   = rr_pick(bus.req, last_q);
    pick_other = rr_pick(bus.req & ~gnt_q, last_q);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    blank_cnt_d = blank_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    hold_done_d = hold_done_q;
    gnt_d       = gnt_q;
    cur_src_d   = cur_src_q;
    disp_data_d = disp_data_q;
    pulse_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_all[2]) begin
          state_d     = StBlank;
          gnt_d       = 3'b001 << pick_all[1:0];
          cur_src_d   = pick_all[1:0];
          last_d      = pick_all[1:0];
          blank_cnt_d = '0;
        end
      end
      StBlank: begin
        if (blank_cnt_q >= BlankLast) begin
          state_d     = StShow;
          disp_data_d = owner_data;
          pulse_d     = 1'b1;
          hold_cnt_d  = '0;
          hold_done_d = 1'b0;
        end else begin
          blank_cnt_d = blank_cnt_q + 32'd1;
        end
      end
      StShow: begin
        if (owner_req) disp_data_d = owner_data;
        if (hold_cnt_q < HoldLast) hold_cnt_d = hold_cnt_q + 32'd1;
        hold_done_d = hold_ok;
        if (hold_ok) begin
          if (pick_other[2]) begin
            state_d     = StBlank;
            gnt_d       = 3'b001 << pick_other[1:0];
            cur_src_d   = pick_other[1:0];
            last_d      = pick_other[1:0];
            blank_cnt_d = '0;
          end else if (!owner_req) begin
            state_d   = StIdle;
            gnt_d     = 3'b000;
            cur_src_d = 2'd3;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        gnt_d     = 3'b000;
        cur_src_d = 2'd3;
      end
    endcase
    // disp_on only gates the enable; arbitration is unaffected.
    en_d = (state_d == StShow) && bus.disp_on;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      last_q      <= 2'd2;
      blank_cnt_q <= '0;
      hold_cnt_q  <= '0;
      hold_done_q <= 1'b0;
      gnt_q       <= 3'b000;
      cur_src_q   <= 2'd3;
      disp_data_q <= '0;
      en_q        <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      blank_cnt_q <= blank_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_done_q <= hold_done_d;
      gnt_q       <= gnt_d;
      cur_src_q   <= cur_src_d;
      disp_data_q <= disp_data_d;
      en_q        <= en_d;
      pulse_q     <= pulse_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.cur_src      = cur_src_q;
  assign bus.disp_data    = disp_data_q;
  assign bus.en           = en_q;
  assign bus.switch_pulse = pulse_q;

endmodule

// File: tb/tb_tube_disp_arbiter.sv
// Directed bench for tube_disp_arbiter with HOLD_CYC=8, BLANK_CYC=2.
module tb_tube_disp_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  tube_disp_arbiter_if bus ();

  tube_disp_arbiter #(
    .HOLD_CYC (8),
    .BLANK_CYC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One round-robin owner period: 2 blank cycles then 8 show cycles.
  task automatic rr_period(input logic [2:0] g);
    for (int i = 0; i < 2; i++) begin
      chk("rr_blank_gnt", 32'(bus.gnt), 32'(g));
      chk("rr_blank_en", 32'(bus.en), 32'd0);
      nc(1);
    end
    for (int i = 0; i < 8; i++) begin
      chk("rr_show_gnt", 32'(bus.gnt), 32'(g));
      chk("rr_show_en", 32'(bus.en), 32'd1);
      chk("rr_show_pulse", 32'(bus.switch_pulse), (i == 0) ? 32'd1 : 32'd0);
      nc(1);
    end
  endtask

  initial begin
    bus.req       = 3'b000;
    bus.disp_on   = 1'b1;
    bus.src0_data = 32'h0;
    bus.src1_data = 32'hcafe0001;
    bus.src2_data = 32'h2222aaaa;

    // Reset state
    nc(2);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_cur", 32'(bus.cur_src), 32'd3);
    chk("rst_en", 32'(bus.en), 32'd0);
    chk("rst_disp", bus.disp_data, 32'h0);
    chk("rst_pulse", 32'(bus.switch_pulse), 32'd0);
    rst = 1'b1;
    nc(1);
    chk("idle_gnt", 32'(bus.gnt), 32'd0);

    // Single source
    bus.req       = 3'b001;
    bus.src0_data = 32'h01234567;
    nc(1);
    chk("s_gnt", 32'(bus.gnt), 32'd1);
    chk("s_cur", 32'(bus.cur_src), 32'd0);
    chk("s_blank_en0", 32'(bus.en), 32'd0);
    nc(1);
    chk("s_blank_en1", 32'(bus.en), 32'd0);
    chk("s_blank_pulse", 32'(bus.switch_pulse), 32'd0);
    nc(1);
    chk("s_pulse", 32'(bus.switch_pulse), 32'd1);
    chk("s_en", 32'(bus.en), 32'd1);
    chk("s_disp", bus.disp_data, 32'h01234567);
    bus.src0_data = 32'h89abcdef;
    bus.req       = 3'b011;
    nc(1);
    chk("s_follow", bus.disp_data, 32'h89abcdef);
    chk("s_pulse_off", 32'(bus.switch_pulse), 32'd0);

    // Hold enforcement: req[1] raised at show cycle 1
    nc(6);
    chk("h_gnt_c8", 32'(bus.gnt), 32'd1);
    chk("h_en_c8", 32'(bus.en), 32'd1);
    nc(1);
    chk("h_gnt_sw", 32'(bus.gnt), 32'd2);
    chk("h_cur_sw", 32'(bus.cur_src), 32'd1);
    chk("h_blank_en0", 32'(bus.en), 32'd0);
    nc(1);
    chk("h_blank_en1", 32'(bus.en), 32'd0);
    nc(1);
    chk("h_show_en", 32'(bus.en), 32'd1);
    chk("h_show_pulse", 32'(bus.switch_pulse), 32'd1);
    chk("h_show_disp", bus.disp_data, 32'hcafe0001);

    // disp_on gating during source 1 show
    bus.disp_on = 1'b0;
    nc(1);
    chk("d_en_off", 32'(bus.en), 32'd0);
    chk("d_gnt", 32'(bus.gnt), 32'd2);
    chk("d_disp", bus.disp_data, 32'hcafe0001);
    bus.disp_on = 1'b1;
    nc(1);
    chk("d_en_on", 32'(bus.en), 32'd1);
    nc(5);
    chk("d_gnt_c8", 32'(bus.gnt), 32'd2);
    chk("d_en_c8", 32'(bus.en), 32'd1);
    nc(1);
    chk("d_gnt_back0", 32'(bus.gnt), 32'd1);
    chk("d_en_blank", 32'(bus.en), 32'd0);
    nc(2);
    chk("r_pre_en", 32'(bus.en), 32'd1);
    chk("r_pre_gnt", 32'(bus.gnt), 32'd1);

    // Asynchronous reset mid-show, checked before the next clock edge
    #2 rst = 1'b0;
    #1;
    chk("ar_gnt", 32'(bus.gnt), 32'd0);
    chk("ar_en", 32'(bus.en), 32'd0);
    chk("ar_disp", bus.disp_data, 32'h0);
    chk("ar_cur", 32'(bus.cur_src), 32'd3);
    nc(1);
    bus.req = 3'b111;
    rst     = 1'b1;
    nc(1);

    // Round robin with all requesting
    rr_period(3'b001);
    rr_period(3'b010);
    rr_period(3'b100);
    chk("rr_wrap_gnt", 32'(bus.gnt), 32'd1);
    chk("rr_wrap_en", 32'(bus.en), 32'd0);

    // Owner 0 drops during blank; still shown, then source 2 takes over
    bus.req = 3'b100;
    nc(2);
    chk("b_show_gnt", 32'(bus.gnt), 32'd1);
    chk("b_show_en", 32'(bus.en), 32'd1);
    chk("b_show_pulse", 32'(bus.switch_pulse), 32'd1);
    chk("b_show_disp", bus.disp_data, 32'h89abcdef);
    nc(7);
    chk("b_gnt_c8", 32'(bus.gnt), 32'd1);
    nc(1);
    chk("b_gnt_2", 32'(bus.gnt), 32'd4);
    chk("b_cur_2", 32'(bus.cur_src), 32'd2);
    chk("b_en_blank", 32'(bus.en), 32'd0);
    nc(2);
    chk("l_show_en", 32'(bus.en), 32'd1);
    chk("l_show_disp", bus.disp_data, 32'h2222aaaa);

    // Release by sole owner at show cycle 3
    nc(2);
    bus.req       = 3'b000;
    bus.src2_data = 32'h2222bbbb;
    nc(1);
    chk("l_frozen", bus.disp_data, 32'h2222aaaa);
    chk("l_en_held", 32'(bus.en), 32'd1);
    nc(4);
    chk("l_gnt_c8", 32'(bus.gnt), 32'd4);
    chk("l_en_c8", 32'(bus.en), 32'd1);
    nc(1);
    chk("l_idle_gnt", 32'(bus.gnt), 32'd0);
    chk("l_idle_cur", 32'(bus.cur_src), 32'd3);
    chk("l_idle_en", 32'(bus.en), 32'd0);
    chk("l_idle_disp", bus.disp_data, 32'h2222aaaa);
    nc(1);
    chk("l_idle_stay", 32'(bus.gnt), 32'd0);
    bus.req = 3'b100;
    nc(1);
    chk("l_re_gnt", 32'(bus.gnt), 32'd4);
    chk("l_re_en", 32'(bus.en), 32'd0);
    nc(2);
    chk("l_re_en_on", 32'(bus.en), 32'd1);
    chk("l_re_disp", bus.disp_data, 32'h2222bbbb);
    chk("l_re_pulse", 32'(bus.switch_pulse), 32'd1);

    // Owner released while another requests: goes to blank, not idle
    bus.req = 3'b010;
    nc(7);
    chk("x_gnt_c8", 32'(bus.gnt), 32'd4);
    chk("x_disp_frozen", bus.disp_data, 32'h2222bbbb);
    nc(1);
    chk("x_gnt_1", 32'(bus.gnt), 32'd2);
    chk("x_en_blank", 32'(bus.en), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
